bus_endpoint_fifo: RTL and testbench

Terminal-side endpoint of the bs_gnrtr_n_rbtr bus: the device that the bus arbiter pops from and pushes into. It holds a TX FIFO, loaded by the local host, that presents pndng/D_pop to the bus and is drained by bus pop. It also holds an RX FIFO that accepts bus push/D_push, filtered by destination ID, and is drained by the local host. One instance sits at each of the DRVS bus ports.

---
 rtl/bus_pkg.sv | 24 ++
 rtl/sync_fifo_fwft.sv | 68 ++++++
 rtl/bus_endpoint_fifo.sv | 111 +++++++++++
 tb/tb_bus_endpoint_fifo.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and helpers for the bus endpoint FIFO slice.
// Optional feature macro used by this slice: BUS_ENDPOINT_STATS_EN.
`default_nettype none

package bus_pkg;

  localparam int ID_W  = 8;
  localparam int MAX_W = 64;

  localparam logic [ID_W-1:0] BROADCAST_ID = 8'hFF;

  localparam int ERR_WR_FULL   = 0;
  localparam int ERR_POP_EMPTY = 1;
  localparam int ERR_RX_OVF    = 2;

  // Caller zero-extends the packet to MAX_W and passes its real width.
  function automatic logic [ID_W-1:0] pkt_dest(input logic [MAX_W-1:0] pkt,
                                               input int unsigned     w);
    return ID_W'(pkt >> (w - ID_W));
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: count-based synchronous FIFO with show-ahead read data.
// Reports rejected writes (full) and rejected reads (empty) for one cycle.
`default_nettype none

module sync_fifo_fwft #(
  parameter int width = 16,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [width-1:0] wdata,
  input  logic             rd,
  output logic [width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             wr_rej,
  output logic             rd_rej
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [width-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_en, rd_en;

  assign full   = (count_q == FULL_CNT);
  assign empty  = (count_q == '0);
  // A full FIFO refuses writes even when a read frees a slot in the same cycle.
  assign wr_en  = wr && !full;
  assign rd_en  = rd && !empty;
  assign wr_rej = wr && full;
  assign rd_rej = rd && empty;
  assign rdata  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (wr_en && !rd_en) count_d = count_q + 1'b1;
    else if (!wr_en && rd_en) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/bus_endpoint_fifo.sv
// bus_endpoint_fifo: bus-side TX/RX FIFO endpoint with destination-ID filter.
// Define BUS_ENDPOINT_STATS_EN to add rx_drop_cnt / tx_sent_cnt outputs.
`default_nettype none

module bus_endpoint_fifo
  import bus_pkg::*;
#(
  parameter int          width = 16,
  parameter int          DEPTH = 16,
  parameter logic [7:0]  MY_ID = 8'd0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             host_wr,
  input  logic [width-1:0] host_wdata,
  output logic             host_full,
  input  logic             host_rd,
  output logic [width-1:0] host_rdata,
  output logic             host_empty,
  output logic             pndng,
  output logic [width-1:0] D_pop,
  input  logic             pop,
  input  logic             push,
  input  logic [width-1:0] D_push,
`ifdef BUS_ENDPOINT_STATS_EN
  output logic [15:0]      rx_drop_cnt,
  output logic [15:0]      tx_sent_cnt,
`endif
  output logic [2:0]       err_flags
);

  logic tx_empty, tx_wr_rej, tx_rd_rej;
  logic rx_wr_rej, rx_rd_rej_unused;
  logic id_match, rx_wr;
  logic [2:0] err_q, err_d;

  assign id_match = (pkt_dest(MAX_W'(D_push), width) == MY_ID) ||
                    (pkt_dest(MAX_W'(D_push), width) == BROADCAST_ID);
  assign rx_wr    = push && id_match;
  assign pndng    = !tx_empty;

  sync_fifo_fwft #(.width(width), .DEPTH(DEPTH)) u_tx (
    .clk    (clk),
    .reset  (reset),
    .wr     (host_wr),
    .wdata  (host_wdata),
    .rd     (pop),
    .rdata  (D_pop),
    .full   (host_full),
    .empty  (tx_empty),
    .wr_rej (tx_wr_rej),
    .rd_rej (tx_rd_rej)
  );

  // Host reads of an empty RX FIFO are deliberately not flagged.
  sync_fifo_fwft #(.width(width), .DEPTH(DEPTH)) u_rx (
    .clk    (clk),
    .reset  (reset),
    .wr     (rx_wr),
    .wdata  (D_push),
    .rd     (host_rd),
    .rdata  (host_rdata),
    .full   (),
    .empty  (host_empty),
    .wr_rej (rx_wr_rej),
    .rd_rej (rx_rd_rej_unused)
  );

  always_comb begin
    err_d = err_q;
    err_d[ERR_WR_FULL]   = err_q[ERR_WR_FULL]   | tx_wr_rej;
    err_d[ERR_POP_EMPTY] = err_q[ERR_POP_EMPTY] | tx_rd_rej;
    err_d[ERR_RX_OVF]    = err_q[ERR_RX_OVF]    | rx_wr_rej;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= '0;
    else        err_q <= err_d;
  end

  assign err_flags = err_q;

`ifdef BUS_ENDPOINT_STATS_EN
  logic [15:0] drop_q, drop_d, sent_q, sent_d;

  always_comb begin
    drop_d = drop_q;
    sent_d = sent_q;
    if (((push && !id_match) || rx_wr_rej) && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
    if (pop && !tx_empty && (sent_q != 16'hFFFF))
      sent_d = sent_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
      sent_q <= '0;
    end else begin
      drop_q <= drop_d;
      sent_q <= sent_d;
    end
  end

  assign rx_drop_cnt = drop_q;
  assign tx_sent_cnt = sent_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bus_endpoint_fifo.sv
// tb_bus_endpoint_fifo: directed self-checking bench for bus_endpoint_fifo.
`default_nettype none

module tb_bus_endpoint_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        host_wr = 1'b0;
  logic [15:0] host_wdata = '0;
  logic        host_full;
  logic        host_rd = 1'b0;
  logic [15:0] host_rdata;
  logic        host_empty;
  logic        pndng;
  logic [15:0] D_pop;
  logic        pop = 1'b0;
  logic        push = 1'b0;
  logic [15:0] D_push = '0;
  logic [2:0]  err_flags;
`ifdef BUS_ENDPOINT_STATS_EN
  logic [15:0] rx_drop_cnt, tx_sent_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  bus_endpoint_fifo #(.width(16), .DEPTH(16), .MY_ID(8'd3)) dut (
    .clk        (clk),
    .reset      (reset),
    .host_wr    (host_wr),
    .host_wdata (host_wdata),
    .host_full  (host_full),
    .host_rd    (host_rd),
    .host_rdata (host_rdata),
    .host_empty (host_empty),
    .pndng      (pndng),
    .D_pop      (D_pop),
    .pop        (pop),
    .push       (push),
    .D_push     (D_push),
`ifdef BUS_ENDPOINT_STATS_EN
    .rx_drop_cnt(rx_drop_cnt),
    .tx_sent_cnt(tx_sent_cnt),
`endif
    .err_flags  (err_flags)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".pndng"},      32'(pndng),      32'd0);
    chk({tag, ".D_pop"},      32'(D_pop),      32'd0);
    chk({tag, ".host_full"},  32'(host_full),  32'd0);
    chk({tag, ".host_empty"}, 32'(host_empty), 32'd1);
    chk({tag, ".host_rdata"}, 32'(host_rdata), 32'd0);
    chk({tag, ".err"},        32'(err_flags),  32'd0);
  endtask

  initial begin
    // Reset
    tick(); tick();
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // Single TX write then pop
    host_wr = 1'b1; host_wdata = 16'h05A1;
    tick();
    host_wr = 1'b0;
    chk("tx1.pndng", 32'(pndng), 32'd1);
    chk("tx1.D_pop", 32'(D_pop), 32'h05A1);
    pop = 1'b1;
    tick();
    pop = 1'b0;
    chk("tx1.pndng_after", 32'(pndng), 32'd0);
    chk("tx1.D_pop_after", 32'(D_pop), 32'd0);

    // Fill TX, overfill, drain in order
    for (int i = 0; i < 16; i++) begin
      host_wr = 1'b1; host_wdata = 16'(i);
      tick();
    end
    chk("txfill.full", 32'(host_full), 32'd1);
    host_wdata = 16'h00FF;
    tick();
    host_wr = 1'b0;
    chk("txfill.err", 32'(err_flags), 32'b001);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("txdrain.%0d", i), 32'(D_pop), 32'(i));
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
    chk("txdrain.pndng", 32'(pndng), 32'd0);
    chk("txdrain.full", 32'(host_full), 32'd0);

    // RX ID filter (MY_ID = 3)
    push = 1'b1; D_push = 16'h03AA; tick();
    D_push = 16'hFF55; tick();
    D_push = 16'h0711; tick();
    push = 1'b0;
    chk("rxf.empty", 32'(host_empty), 32'd0);
    chk("rxf.head0", 32'(host_rdata), 32'h03AA);
    host_rd = 1'b1; tick();
    chk("rxf.head1", 32'(host_rdata), 32'hFF55);
    tick();
    host_rd = 1'b0;
    chk("rxf.empty_after", 32'(host_empty), 32'd1);
    chk("rxf.rdata_after", 32'(host_rdata), 32'd0);
`ifdef BUS_ENDPOINT_STATS_EN
    chk("rxf.drop_cnt", 32'(rx_drop_cnt), 32'd1);
`endif

    // RX overflow with concurrent host_rd
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; D_push = 16'h0300 + 16'(i);
      tick();
    end
    D_push = 16'h0399; host_rd = 1'b1;
    tick();
    push = 1'b0; host_rd = 1'b0;
    chk("rxovf.err", 32'(err_flags), 32'b101);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("rxovf.rd%0d", i), 32'(host_rdata), 32'h0300 + 32'(i));
      host_rd = 1'b1;
      tick();
    end
    host_rd = 1'b0;
    chk("rxovf.empty", 32'(host_empty), 32'd1);
`ifdef BUS_ENDPOINT_STATS_EN
    chk("rxovf.drop_cnt", 32'(rx_drop_cnt), 32'd2);
`endif

    // TX simultaneous write/pop at count=1, then pop when empty
    host_wr = 1'b1; host_wdata = 16'h0A0A; tick();
    host_wdata = 16'h0B0B; pop = 1'b1; tick();
    host_wr = 1'b0; pop = 1'b0;
    chk("txsim.D_pop", 32'(D_pop), 32'h0B0B);
    chk("txsim.pndng", 32'(pndng), 32'd1);
    pop = 1'b1; tick();
    chk("txsim.drained", 32'(pndng), 32'd0);
    chk("txsim.err_before", 32'(err_flags), 32'b101);
    tick();
    pop = 1'b0;
    chk("txsim.err_after", 32'(err_flags), 32'b111);
`ifdef BUS_ENDPOINT_STATS_EN
    chk("txsim.sent_cnt", 32'(tx_sent_cnt), 32'd19);
`endif

    // Mid-stream async reset with both FIFOs holding 8 entries
    for (int i = 0; i < 8; i++) begin
      host_wr = 1'b1; host_wdata = 16'h1000 + 16'(i);
      push = 1'b1;    D_push = 16'h0320 + 16'(i);
      tick();
    end
    host_wr = 1'b0; push = 1'b0;
    chk("mid.pndng", 32'(pndng), 32'd1);
    chk("mid.rx_head", 32'(host_rdata), 32'h0320);
    #2 reset = 1'b0;
    #1;
    chk_reset_outputs("async");
`ifdef BUS_ENDPOINT_STATS_EN
    chk("async.drop_cnt", 32'(rx_drop_cnt), 32'd0);
    chk("async.sent_cnt", 32'(tx_sent_cnt), 32'd0);
`endif
    tick(); tick();
    #2 reset = 1'b1;
    tick();
    chk_reset_outputs("release");
    host_wr = 1'b1; host_wdata = 16'h2222; tick();
    host_wr = 1'b0;
    chk("post.D_pop", 32'(D_pop), 32'h2222);
    push = 1'b1; D_push = 16'hFF33; tick();
    push = 1'b0;
    chk("post.host_rdata", 32'(host_rdata), 32'hFF33);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
